// File: rtl/team_04_gpio_in_cond_if.sv
// Signal bundle between the team_04 pad inputs, the wrapper and the input conditioning stage.
interface team_04_gpio_in_cond_if #(
    parameter int unsigned N_IN = 4
);
    logic            en_i;
    logic [N_IN-1:0] pad_i;
    logic [N_IN-1:0] clr_i;
    logic [N_IN-1:0] level_o;
    logic [N_IN-1:0] rise_o;
    logic [N_IN-1:0] fall_o;
    logic [N_IN-1:0] evt_o;

    modport master (
        output en_i, pad_i, clr_i,
        input  level_o, rise_o, fall_o, evt_o
    );

    modport slave (
        input  en_i, pad_i, clr_i,
        output level_o, rise_o, fall_o, evt_o
    );
endinterface

// File: rtl/team_04_gpio_in_cond.sv
// Per-channel 2-flop synchronizer, consecutive-sample debouncer and rise/fall pulse generator.
// Define TEAM_04_IN_STICKY_EN to build the sticky rising-edge event register (evt_o/clr_i).
module team_04_gpio_in_cond #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned DEBOUNCE = 4
) (
    input logic                   wb_clk_i,
    input logic                   wb_rst_i,
    team_04_gpio_in_cond_if.slave bus
);
    localparam int unsigned   CW      = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [N_IN-1:0]         r_s1;
    logic [N_IN-1:0]         r_s2;
    logic [N_IN-1:0]         r_level;
    logic [N_IN-1:0]         r_rise;
    logic [N_IN-1:0]         r_fall;
    logic [N_IN-1:0][CW-1:0] r_cnt;

    logic [N_IN-1:0]         w_level_d;
    logic [N_IN-1:0]         w_rise_d;
    logic [N_IN-1:0]         w_fall_d;
    logic [N_IN-1:0][CW-1:0] w_cnt_d;

    // Counter only advances while the synced sample disagrees; it commits at CNT_MAX, never wraps.
    always_comb begin
        w_level_d = r_level;
        w_rise_d  = '0;
        w_fall_d  = '0;
        w_cnt_d   = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (bus.en_i && (r_s2[i] != r_level[i])) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_level_d[i] = r_s2[i];
                    w_rise_d[i]  = r_s2[i];
                    w_fall_d[i]  = ~r_s2[i];
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= bus.pad_i;
            r_s2    <= r_s1;
            r_level <= w_level_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign bus.level_o = r_level;
    assign bus.rise_o  = r_rise;
    assign bus.fall_o  = r_fall;

`ifdef TEAM_04_IN_STICKY_EN
    logic [N_IN-1:0] r_evt;

    // A new rise overrides a coincident clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~bus.clr_i) | r_rise;
        end
    end

    assign bus.evt_o = r_evt;
`else
    logic [N_IN-1:0] w_unused_clr;

    assign w_unused_clr = bus.clr_i;
    assign bus.evt_o    = '0;
`endif
endmodule
